multicycle_controller: RTL and testbench

Control unit for the multicycle RISC-V core. It sequences the shared datapath through fetch, decode, execute, memory and writeback. It drives mux selects, ALU control and write enables from the current FSM state, the instruction fields and the `Zero` flag. It replaces the single-cycle decoder inside `top` and supports lw, sw, R-type ALU, I-type ALU, beq and jal.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multicycle RISC-V core.
// It sequences fetch, decode, execute, memory and writeback on the shared datapath.
// Fetch, MemRead and MemWrite each hold for MEM_WAIT+1 cycles.
// The write strobes in those states fire only in the final cycle.
module multicycle_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic       CLK,
    input  logic       ResetN,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    localparam int            CW       = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          mem_state;
    logic          last;

    logic [1:0]    aluop;
    logic          pcupdate;
    logic          branch;
    logic          irwrite_raw;
    logic          regwrite_raw;
    logic          memwrite_raw;

    // Memory-access states stretch; every other state lasts exactly one cycle.
    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign last      = !mem_state || (cnt == CNT_LAST);

    // State register; reset lands in Fetch regardless of where the instruction was.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter: counts cycles spent in a memory state and clears on every transition.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (mem_state && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Next-state logic; memory states advance only once their wait has elapsed.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (last) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (last) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (last) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Per-state Moore controls; selects hold for the whole state, strobes are raw here.
    always_comb begin
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        AdrSrc       = 1'b0;
        aluop        = 2'b00;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = 1'b1;
                pcupdate    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            default: begin
                ALUSrcA = 2'b00;
            end
        endcase
    end

    // Strobes are qualified by the final wait cycle and forced low while reset is held.
    assign IRWrite  = ResetN & irwrite_raw & last;
    assign PCWrite  = ResetN & ((pcupdate & last) | (branch & Zero));
    assign RegWrite = ResetN & regwrite_raw;
    assign MemWrite = ResetN & memwrite_raw & last;

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder; only R-type uses funct7b5 to select subtract.
    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance with MEM_WAIT=0 and one with MEM_WAIT=2.
// Outputs are packed as {ImmSrc,ALUSrcA,ALUSrcB,ResultSrc,AdrSrc,ALUControl,IRWrite,PCWrite,RegWrite,MemWrite}.
module tb_multicycle_controller;

    logic CLK;

    logic       rst0, f7_0, z0;
    logic [6:0] op0;
    logic [2:0] f3_0;
    logic [1:0] imm0, sa0, sb0, rs0;
    logic       adr0, ir0, pc0, rw0, mw0;
    logic [2:0] alu0;

    logic       rst2, f7_2, z2;
    logic [6:0] op2;
    logic [2:0] f3_2;
    logic [1:0] imm2, sa2, sb2, rs2;
    logic       adr2, ir2, pc2, rw2, mw2;
    logic [2:0] alu2;

    logic [15:0] obs0, obs2;
    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.MEM_WAIT(0)) dut0 (
        .CLK(CLK), .ResetN(rst0), .op(op0), .funct3(f3_0), .funct7b5(f7_0), .Zero(z0),
        .ImmSrc(imm0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0), .AdrSrc(adr0),
        .ALUControl(alu0), .IRWrite(ir0), .PCWrite(pc0), .RegWrite(rw0), .MemWrite(mw0)
    );

    multicycle_controller #(.MEM_WAIT(2)) dut2 (
        .CLK(CLK), .ResetN(rst2), .op(op2), .funct3(f3_2), .funct7b5(f7_2), .Zero(z2),
        .ImmSrc(imm2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ResultSrc(rs2), .AdrSrc(adr2),
        .ALUControl(alu2), .IRWrite(ir2), .PCWrite(pc2), .RegWrite(rw2), .MemWrite(mw2)
    );

    assign obs0 = {imm0, sa0, sb0, rs0, adr0, alu0, ir0, pc0, rw0, mw0};
    assign obs2 = {imm2, sa2, sb2, rs2, adr2, alu2, ir2, pc2, rw2, mw2};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected output word; en = {IRWrite, PCWrite, RegWrite, MemWrite}.
    function automatic logic [15:0] v(input logic [1:0] imm, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] rs, input logic adr, input logic [2:0] alu,
                                      input logic [3:0] en);
        return {imm, a, b, rs, adr, alu, en};
    endfunction

    function automatic logic [15:0] fetch_v(input logic [1:0] imm, input logic [3:0] en);
        return v(imm, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, en);
    endfunction

    function automatic logic [15:0] decode_v(input logic [1:0] imm);
        return v(imm, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        rst0 = 1'b0; op0 = 7'b0110011; f3_0 = 3'b000; f7_0 = 1'b1; z0 = 1'b0;
        rst2 = 1'b0; op2 = 7'b0000011; f3_2 = 3'b010; f7_2 = 1'b0; z2 = 1'b0;
        #1;
        // Reset held three cycles: Fetch selects, no enables.
        chk("rst_hold0", obs0, fetch_v(2'b00, 4'b0000));
        step(); chk("rst_hold1", obs0, fetch_v(2'b00, 4'b0000));
        step(); chk("rst_hold2", obs0, fetch_v(2'b00, 4'b0000));
        step(); chk("rst_hold3", obs0, fetch_v(2'b00, 4'b0000));
        rst0 = 1'b1; #1;
        // Release: Fetch completes, then the sub instruction already on the bus runs.
        chk("rel_fetch", obs0, fetch_v(2'b00, 4'b1100));
        step(); chk("rel_decode", obs0, decode_v(2'b00));
        step(); chk("sub_execr", obs0, v(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 4'b0000));
        step(); chk("sub_aluwb", obs0, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010));
        step();

        // lw 0x00402103
        op0 = 7'b0000011; f3_0 = 3'b010; f7_0 = 1'b0; #1;
        chk("lw_c1", obs0, fetch_v(2'b00, 4'b1100));
        step(); chk("lw_c2", obs0, decode_v(2'b00));
        step(); chk("lw_c3", obs0, v(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000));
        step(); chk("lw_c4", obs0, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000));
        step(); chk("lw_c5", obs0, v(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 4'b0010));
        step();

        // sw
        op0 = 7'b0100011; f3_0 = 3'b010; #1;
        chk("sw_c1", obs0, fetch_v(2'b01, 4'b1100));
        step(); chk("sw_c2", obs0, decode_v(2'b01));
        step(); chk("sw_c3", obs0, v(2'b01, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000));
        step(); chk("sw_c4", obs0, v(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0001));
        step(); chk("sw_next", obs0, fetch_v(2'b01, 4'b1100));

        // and (R-type, funct3=111)
        op0 = 7'b0110011; f3_0 = 3'b111; f7_0 = 1'b0;
        step(); step();
        chk("and_execr", obs0, v(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b010, 4'b0000));
        step(); step();

        // addi with Instr[30]=1 must still add
        op0 = 7'b0010011; f3_0 = 3'b000; f7_0 = 1'b1;
        step(); step();
        chk("addi_execi", obs0, v(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000));
        step(); chk("addi_aluwb", obs0, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010));
        step();

        // slti
        f3_0 = 3'b010; f7_0 = 1'b0;
        step(); step();
        chk("slti_execi", obs0, v(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b101, 4'b0000));
        step(); step();

        // beq taken
        op0 = 7'b1100011; f3_0 = 3'b000; #1;
        chk("beq_c1", obs0, fetch_v(2'b10, 4'b1100));
        step(); chk("beq_c2", obs0, decode_v(2'b10));
        step(); z0 = 1'b1; #1;
        chk("beq_taken", obs0, v(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 4'b0100));
        step(); z0 = 1'b0; #1;
        chk("beq_taken_next", obs0, fetch_v(2'b10, 4'b1100));
        // beq not taken, then Zero toggled within the BEQ cycle
        step();
        step(); chk("beq_not_taken", obs0, v(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 4'b0000));
        z0 = 1'b1; #1;
        chk("beq_zero_comb", obs0, v(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 4'b0100));
        z0 = 1'b0;
        step(); chk("beq_nt_next", obs0, fetch_v(2'b10, 4'b1100));

        // jal
        op0 = 7'b1101111;
        step(); chk("jal_c2", obs0, decode_v(2'b11));
        step(); chk("jal_c3", obs0, v(2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 4'b0100));
        step(); chk("jal_c4", obs0, v(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 4'b0010));
        step(); chk("jal_next", obs0, fetch_v(2'b11, 4'b1100));

        // illegal opcode executes as a nop
        op0 = 7'b0000000;
        step(); chk("ill_c2", obs0, decode_v(2'b00));
        step(); chk("ill_next", obs0, fetch_v(2'b00, 4'b1100));

        // asynchronous reset in the middle of lw's MemRead
        op0 = 7'b0000011;
        step(); step(); step();
        chk("ar_memread", obs0, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000));
        #2; rst0 = 1'b0; #1;
        chk("ar_async", obs0, fetch_v(2'b00, 4'b0000));
        step(); rst0 = 1'b1; #1;
        chk("ar_rel_fetch", obs0, fetch_v(2'b00, 4'b1100));
        step(); chk("ar_rel_decode", obs0, decode_v(2'b00));

        // MEM_WAIT=2: lw over 9 cycles, then an illegal opcode
        chk("w_rst", obs2, fetch_v(2'b00, 4'b0000));
        rst2 = 1'b1; #1;
        chk("w_lw_c1", obs2, fetch_v(2'b00, 4'b0000));
        step(); chk("w_lw_c2", obs2, fetch_v(2'b00, 4'b0000));
        step(); chk("w_lw_c3", obs2, fetch_v(2'b00, 4'b1100));
        step(); chk("w_lw_c4", obs2, decode_v(2'b00));
        step(); chk("w_lw_c5", obs2, v(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 4'b0000));
        step(); chk("w_lw_c6", obs2, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000));
        step(); chk("w_lw_c7", obs2, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000));
        step(); chk("w_lw_c8", obs2, v(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 4'b0000));
        step(); chk("w_lw_c9", obs2, v(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 4'b0010));
        step(); op2 = 7'b0000000; #1;
        chk("w_ill_c1", obs2, fetch_v(2'b00, 4'b0000));
        step(); chk("w_ill_c2", obs2, fetch_v(2'b00, 4'b0000));
        step(); chk("w_ill_c3", obs2, fetch_v(2'b00, 4'b1100));
        step(); chk("w_ill_c4", obs2, decode_v(2'b00));
        step(); chk("w_ill_next", obs2, fetch_v(2'b00, 4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
